// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state, owner and width constants for the memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2,
        S_RWAIT = 2'd3
    } state_e;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational icache/dcache arbitration; grant_o carries the owner code.
// Round-robin when MEM_ARB_RR_EN is defined, otherwise fixed dcache priority.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic ic_valid_i,
    input  logic dc_valid_i,
    input  logic last_i,
    output logic grant_o
);

`ifdef MEM_ARB_RR_EN
    always_comb grant_o = (ic_valid_i && dc_valid_i) ? !last_i : (dc_valid_i ? OWN_DC : OWN_IC);
`else
    logic unused_last;
    assign unused_last = last_i;
    always_comb grant_o = dc_valid_i ? OWN_DC : OWN_IC;
    // ic_valid_i only matters when dc is idle, which the caller's valid qualification covers
    logic unused_ic;
    assign unused_ic = ic_valid_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter between icache refills and dcache reads/writes.
// Grant policy selected by MEM_ARB_RR_EN (round-robin) vs. default fixed dcache priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,
    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic [DATA_W-1:0]   dc_req_data,
    input  logic [DATA_W/8-1:0] dc_req_mask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,
    output logic                dc_wr_done,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_data_valid,
    input  logic                mem_data_ready,
    output logic [DATA_W-1:0]   mem_data_bits,
    output logic [DATA_W/8-1:0] mem_data_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    localparam int MASK_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                own_q, own_d;
    logic                rw_q, rw_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                grant, idle, ic_gnt, dc_gnt, rd_hit;

    mem_arb_pick u_pick (
        .ic_valid_i (ic_req_valid),
        .dc_valid_i (dc_req_valid),
        .last_i     (last_q),
        .grant_o    (grant)
    );

    assign idle   = state_q == S_IDLE;
    assign ic_gnt = idle && ic_req_valid && grant == OWN_IC;
    assign dc_gnt = idle && dc_req_valid && grant == OWN_DC;
    assign rd_hit = state_q == S_RWAIT && mem_resp_valid;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        rw_d    = rw_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: if (ic_gnt || dc_gnt) begin
                state_d = S_CMD;
                own_d   = dc_gnt ? OWN_DC : OWN_IC;
                last_d  = dc_gnt ? OWN_DC : OWN_IC;
                // icache refills are always reads with an empty mask
                rw_d    = dc_gnt && dc_req_rw;
                addr_d  = dc_gnt ? dc_req_addr : ic_req_addr;
                data_d  = dc_gnt ? dc_req_data : '0;
                mask_d  = dc_gnt ? dc_req_mask : '0;
            end
            S_CMD:   if (mem_req_ready) state_d = rw_q ? S_WDATA : S_RWAIT;
            S_WDATA: if (mem_data_ready) state_d = S_IDLE;
            S_RWAIT: if (mem_resp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            own_q   <= OWN_IC;
            rw_q    <= 1'b0;
            last_q  <= OWN_IC;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            rw_q    <= rw_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign ic_req_ready   = ic_gnt;
    assign dc_req_ready   = dc_gnt;
    assign mem_req_valid  = state_q == S_CMD;
    assign mem_req_rw     = rw_q;
    assign mem_req_addr   = addr_q;
    assign mem_data_valid = state_q == S_WDATA;
    assign mem_data_bits  = data_q;
    assign mem_data_mask  = mask_q;
    assign dc_wr_done     = mem_data_valid && mem_data_ready;
    assign ic_resp_valid  = rd_hit && own_q == OWN_IC;
    assign dc_resp_valid  = rd_hit && own_q == OWN_DC;
    assign ic_resp_data   = ic_resp_valid ? mem_resp_data : '0;
    assign dc_resp_data   = dc_resp_valid ? mem_resp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid, dc_wr_done;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data, dc_resp_data;
    logic [MW-1:0] dc_req_mask;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_data_valid, mem_data_ready;
    logic [DW-1:0] mem_data_bits;
    logic [MW-1:0] mem_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_wr_done(dc_wr_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready),
        .mem_data_bits(mem_data_bits), .mem_data_mask(mem_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding request, tracked by whether its command
    // has been accepted yet; winner chosen by the arbitration rule (1 = dcache).
    bit          m_busy, m_cmd, m_own, m_rw, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;
    int          n_done = 0;
    int          n_cmds = 0;
    bit          ic_hs, dc_hs, rec;
    bit          gq[$];
    bit          w, e_icr, e_dcr, hit, wr;

    function automatic bit pick(input bit icv, input bit dcv, input bit last);
`ifdef MEM_ARB_RR_EN
        if (icv && dcv) return !last;
`endif
        return dcv;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_busy = 0;
            m_last = 0;
            ic_hs  = 0;
            dc_hs  = 0;
        end else begin
            w     = pick(ic_req_valid, dc_req_valid, m_last);
            e_icr = !m_busy && ic_req_valid && !w;
            e_dcr = !m_busy && dc_req_valid && w;
            hit   = m_busy && m_cmd && !m_rw && mem_resp_valid;
            wr    = m_busy && m_cmd && m_rw;
            chk("ic_req_ready", ic_req_ready, e_icr);
            chk("dc_req_ready", dc_req_ready, e_dcr);
            chk("mem_req_valid", mem_req_valid, m_busy && !m_cmd);
            if (m_busy && !m_cmd) begin
                chk("mem_req_addr", mem_req_addr, m_addr);
                chk("mem_req_rw", mem_req_rw, m_rw);
            end
            chk("mem_data_valid", mem_data_valid, wr);
            if (wr) begin
                chk("mem_data_bits", mem_data_bits, m_data);
                chk("mem_data_mask", mem_data_mask, m_mask);
            end
            chk("dc_wr_done", dc_wr_done, wr && mem_data_ready);
            chk("ic_resp_valid", ic_resp_valid, hit && !m_own);
            chk("dc_resp_valid", dc_resp_valid, hit && m_own);
            if (hit && !m_own) chk("ic_resp_data", ic_resp_data, mem_resp_data);
            if (hit && m_own) chk("dc_resp_data", dc_resp_data, mem_resp_data);
            ic_hs = ic_req_valid && ic_req_ready;
            dc_hs = dc_req_valid && dc_req_ready;
            if (mem_req_valid && mem_req_ready) n_cmds++;
            if (!m_busy) begin
                if (e_icr || e_dcr) begin
                    m_busy = 1;
                    m_cmd  = 0;
                    m_own  = e_dcr;
                    m_rw   = e_dcr && dc_req_rw;
                    m_addr = e_dcr ? dc_req_addr : ic_req_addr;
                    m_data = dc_req_data;
                    m_mask = e_dcr ? dc_req_mask : '0;
                    m_last = m_own;
                    if (rec) gq.push_back(m_own);
                end
            end else if (!m_cmd) begin
                m_cmd = mem_req_ready;
            end else if (m_rw ? mem_data_ready : mem_resp_valid) begin
                m_busy = 0;
                n_done++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_in();
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_data = '0; dc_req_mask = '0;
        mem_req_ready = 0; mem_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    task automatic rst_pulse();
        cyc();
        clr_in();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DW-1:0] d;
    bit            exp_g;
    int            k;

    initial begin
        clr_in();
        reset = 1;
        rec   = 0;
        repeat (2) cyc();
        smp();
        chk("rst_ic_req_ready", ic_req_ready, 0);
        chk("rst_dc_req_ready", dc_req_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_rw", mem_req_rw, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        chk("rst_mem_data_valid", mem_data_valid, 0);
        chk("rst_mem_data_bits", mem_data_bits, 0);
        chk("rst_mem_data_mask", mem_data_mask, 0);
        chk("rst_ic_resp_valid", ic_resp_valid, 0);
        chk("rst_ic_resp_data", ic_resp_data, 0);
        chk("rst_dc_resp_valid", dc_resp_valid, 0);
        chk("rst_dc_resp_data", dc_resp_data, 0);
        chk("rst_dc_wr_done", dc_wr_done, 0);
        cyc();
        reset = 0;

        // icache read, response two cycles after the command
        ic_req_valid = 1; ic_req_addr = 28'h0000010;
        smp(); chk("ic_rd_grant", ic_req_ready, 1);
        cyc(); ic_req_valid = 0; mem_req_ready = 1;
        smp(); chk("ic_rd_cmd_valid", mem_req_valid, 1); chk("ic_rd_cmd_addr", mem_req_addr, 28'h10);
        chk("ic_rd_cmd_rw", mem_req_rw, 0);
        cyc(); mem_req_ready = 0;
        smp(); chk("ic_rd_no_early_resp", ic_resp_valid, 0);
        d = rnd_data();
        cyc(); mem_resp_valid = 1; mem_resp_data = d;
        smp(); chk("ic_rd_resp_valid", ic_resp_valid, 1); chk("ic_rd_resp_data", ic_resp_data, d);
        chk("ic_rd_dc_quiet", dc_resp_valid, 0);
        cyc(); mem_resp_valid = 0;
        smp(); chk("ic_rd_single_pulse", ic_resp_valid, 0);

        // dcache write with data acceptance delayed three cycles
        d = rnd_data();
        cyc(); dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0000020; dc_req_data = d;
        dc_req_mask = 16'hFFFF;
        smp(); chk("dc_wr_grant", dc_req_ready, 1);
        cyc(); dc_req_valid = 0; mem_req_ready = 1;
        smp(); chk("dc_wr_cmd_rw", mem_req_rw, 1); chk("dc_wr_cmd_addr", mem_req_addr, 28'h20);
        cyc(); mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("dc_wr_hold_valid", mem_data_valid, 1);
            chk("dc_wr_hold_bits", mem_data_bits, d);
            chk("dc_wr_hold_mask", mem_data_mask, 16'hFFFF);
            chk("dc_wr_no_early_done", dc_wr_done, 0);
            cyc();
        end
        mem_data_ready = 1;
        smp(); chk("dc_wr_done_pulse", dc_wr_done, 1);
        cyc(); mem_data_ready = 0;
        smp(); chk("dc_wr_done_single", dc_wr_done, 0); chk("dc_wr_back_idle", mem_data_valid, 0);

        // simultaneous requests for four transactions
        rst_pulse();
        ic_req_valid = 1; ic_req_addr = 28'h100;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h200;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = rnd_data();
        rec = 1;
        for (int i = 0; i < 200 && gq.size() < 4; i++) cyc();
        rec = 0;
        ic_req_valid = 0; dc_req_valid = 0;
        repeat (3) cyc();
        chk("arb_grant_count", gq.size(), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = (i % 2 == 0);
`else
            exp_g = 1;
`endif
            chk($sformatf("arb_grant%0d", i), (i < gq.size()) ? gq[i] : 1'bx, exp_g);
        end

        // reset while waiting for read data
        rst_pulse();
        ic_req_valid = 1; ic_req_addr = 28'h40; mem_req_ready = 1;
        smp(); chk("rst_mid_grant", ic_req_ready, 1);
        cyc(); ic_req_valid = 0;
        smp(); chk("rst_mid_cmd", mem_req_valid, 1);
        cyc(); mem_req_ready = 0; reset = 1;
        d = rnd_data();
        cyc(); reset = 0; mem_resp_valid = 1; mem_resp_data = d;
        smp(); chk("rst_mid_no_ic_resp", ic_resp_valid, 0); chk("rst_mid_no_dc_resp", dc_resp_valid, 0);
        cyc(); mem_resp_valid = 0; ic_req_valid = 1; ic_req_addr = 28'h50;
        smp(); chk("rst_after_grant", ic_req_ready, 1);
        cyc(); ic_req_valid = 0; mem_req_ready = 1;
        smp(); chk("rst_after_cmd_addr", mem_req_addr, 28'h50);
        d = rnd_data();
        cyc(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = d;
        smp(); chk("rst_after_resp_valid", ic_resp_valid, 1); chk("rst_after_resp_data", ic_resp_data, d);
        cyc(); mem_resp_valid = 0;

        // command held off for ten cycles while both requesters wait
        rst_pulse();
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h30;
        smp(); chk("stall_grant", dc_req_ready, 1);
        cyc(); dc_req_addr = 28'h31; ic_req_valid = 1; ic_req_addr = 28'h60;
        k = n_cmds;
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("stall_cmd_valid", mem_req_valid, 1);
            chk("stall_cmd_addr", mem_req_addr, 28'h30);
            chk("stall_cmd_rw", mem_req_rw, 0);
            chk("stall_ic_ready", ic_req_ready, 0);
            chk("stall_dc_ready", dc_req_ready, 0);
            cyc();
        end
        mem_req_ready = 1;
        smp(); chk("stall_cmd_accept", mem_req_valid, 1);
        cyc(); mem_req_ready = 0;
        smp(); chk("stall_cmd_dropped", mem_req_valid, 0); chk("stall_one_cmd", n_cmds - k, 1);
        rst_pulse();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset = ($urandom_range(499) == 0);
            if (ic_hs) ic_req_valid = 0;
            if (!ic_req_valid && $urandom_range(3) == 0) begin
                ic_req_valid = 1;
                ic_req_addr  = AW'($urandom);
            end
            if (dc_hs) dc_req_valid = 0;
            if (!dc_req_valid && $urandom_range(3) == 0) begin
                dc_req_valid = 1;
                dc_req_rw    = 1'($urandom_range(1));
                dc_req_addr  = AW'($urandom);
                dc_req_data  = rnd_data();
                dc_req_mask  = MW'($urandom);
            end
            mem_req_ready  = $urandom_range(2) != 0;
            mem_data_ready = 1'($urandom_range(1));
            mem_resp_valid = $urandom_range(2) == 0;
            mem_resp_data  = rnd_data();
        end
        cyc();
        reset = 0;
        ic_req_valid = 0; dc_req_valid = 0;
        mem_req_ready = 1; mem_data_ready = 1; mem_resp_valid = 1;
        repeat (4) cyc();
        clr_in();
        cyc();
        chk("random_progress", n_done > 200, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 28, cache-line address width (byte address bits [31:4]).
REQ-002 Parameter: DATA_W, 128, cache-line/beat data width; mask width is DATA_W/8.
REQ-003 clk  in  1  sole clock; every state element updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ic_req_valid/ic_req_ready  in/out  1/1  icache refill read request handshake.
REQ-006 ic_req_addr  in  ADDR_W  icache line address.
REQ-007 ic_resp_valid/ic_resp_data  out  1/DATA_W  icache refill data, one-cycle pulse, no backpressure.
REQ-008 dc_req_valid/dc_req_ready  in/out  1/1  dcache request handshake.
REQ-009 dc_req_rw  in  1  dcache request type: 0 read, 1 write.
REQ-010 dc_req_addr  in  ADDR_W  dcache line address.
REQ-011 dc_req_data/dc_req_mask  in  DATA_W/DATA_W/8  dcache write data and byte mask.
REQ-012 dc_resp_valid/dc_resp_data  out  1/DATA_W  dcache read data, one-cycle pulse.
REQ-013 dc_wr_done  out  1  one-cycle pulse when the dcache write data beat is accepted by memory.
REQ-014 mem_req_valid/mem_req_ready/mem_req_rw/mem_req_addr  out/in/out/out  1/1/1/ADDR_W  memory command channel.
REQ-015 mem_data_valid/mem_data_ready/mem_data_bits/mem_data_mask  out/in/out/out  1/1/DATA_W/DATA_W/8  memory write-data channel.
REQ-016 mem_resp_valid/mem_resp_data  in/in  1/DATA_W  memory read response; in order, no backpressure.

Function
REQ-017 States SHALL be IDLE, CMD, WDATA, RWAIT; exactly one transaction is outstanding at any time.
REQ-018 In IDLE, ic_req_ready or dc_req_ready SHALL be asserted only for the winner of arbitration; a grant is the handshake cycle (valid && ready).
REQ-019 At grant, the arbiter SHALL latch owner, rw, addr, data and mask, then go to CMD the next cycle.
REQ-020 In CMD, mem_req_valid=1 with the latched fields; on mem_req_ready it SHALL go to WDATA if rw=1, else to RWAIT.
REQ-021 In WDATA, mem_data_valid=1 with the latched data/mask; on mem_data_ready it SHALL pulse dc_wr_done the same cycle and return to IDLE.
REQ-022 In RWAIT, on mem_resp_valid it SHALL route mem_resp_data to the latched owner's resp_valid/resp_data the same cycle and return to IDLE.
REQ-023 Both *_req_ready SHALL be 0 in all states except IDLE; a pending request stays pending until granted.
REQ-024 ic requests SHALL always be issued with mem_req_rw=0 and mem_data_mask=0.
REQ-025 mem_resp_valid outside RWAIT SHALL be ignored and produce no response pulse.
REQ-026 Minimum read turnaround: grant at cycle N, command at N+1, response no earlier than N+2, next grant no earlier than the response cycle+1.
REQ-027 With only one requester valid, that requester SHALL be granted in the first IDLE cycle.

Reset
REQ-028 Reset SHALL force IDLE, clear owner and last-grant, and drive every valid/ready/pulse output to 0 and all data/address outputs to 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no response or dc_wr_done pulse; a later stale mem_resp_valid is dropped per REQ-025.

Configuration
REQ-030 Macro MEM_ARB_RR_EN defined: when both requesters are valid in IDLE, the grant SHALL alternate relative to the last granted requester (last-grant resets to ic, so dc wins first).
REQ-031 MEM_ARB_RR_EN undefined: dcache SHALL have fixed priority over icache on every simultaneous request.

Structure
REQ-032 State encodings, owner encoding (OWN_IC=0, OWN_DC=1) and default widths SHALL live in the shared constants header.
REQ-033 Arbitration SHALL be a combinational sub-module mem_arb_pick (inputs: two valids, last-grant; output: grant), with the MEM_ARB_RR_EN choice confined to it.

Verification
REQ-034 ic read addr 0x0000010, mem_resp 2 cycles after the command -> one ic_resp_valid pulse carrying that data; dc_resp_valid stays 0.
REQ-035 dc write addr 0x0000020, mask 0xFFFF, mem_data_ready delayed 3 cycles -> data/mask held stable, a single dc_wr_done pulse, then IDLE.
REQ-036 ic and dc valid on the same cycle for 4 transactions -> RR build grants dc,ic,dc,ic; fixed build grants dc four times while ic starves.
REQ-037 reset asserted during RWAIT, then mem_resp_valid -> no response pulse; the next ic request completes normally.
REQ-038 mem_req_ready held low 10 cycles -> command fields stay stable, both req_ready stay 0, and exactly one command is accepted.
